// File: rtl/key_debounce_multi.sv
// key_debounce_multi
// N-channel push-button conditioner. Each channel has a 2-FF synchroniser,
// a four-state debounce FSM, and registered one-cycle press, release, flag and
// long-press pulses alongside the debounced level.
// Optional feature: define KEY_DEBOUNCE_REPEAT_EN to re-pulse key_press every
// REPEAT_CNT cycles once key_long has fired. Without it no repeat logic exists.
module key_debounce_multi #(
  parameter int   KEY_NUM      = 4,
  parameter int   DEBOUNCE_CNT = 1_000_000,
  parameter int   LONG_CNT     = 50_000_000,
  parameter int   REPEAT_CNT   = 10_000_000,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_value,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CNT);
  localparam int HCNT_W = $clog2(LONG_CNT);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CNT - 1);
`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int RCNT_W = $clog2(REPEAT_CNT);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CNT - 1);
`endif

  typedef enum logic [1:0] {
    ST_UP     = 2'd0,
    ST_DN_CHK = 2'd1,
    ST_DOWN   = 2'd2,
    ST_UP_CHK = 2'd3
  } state_t;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    logic              sync1, key_s;
    state_t            state, state_d;
    logic [DCNT_W-1:0] dcnt, dcnt_d;
    logic [HCNT_W-1:0] hcnt, hcnt_d;
    logic              long_done, long_done_d;
    logic              value_q, value_d;
    logic              flag_q, flag_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    logic [RCNT_W-1:0] rcnt, rcnt_d;
`endif

    // Two-flop synchroniser for the asynchronous raw key
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync1 <= IDLE_LEVEL;
        key_s <= IDLE_LEVEL;
      end else begin
        sync1 <= key[i];
        key_s <= sync1;
      end
    end

    // State, counters and registered outputs; reset drops any pending event
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state     <= ST_UP;
        dcnt      <= '0;
        hcnt      <= '0;
        long_done <= 1'b0;
        value_q   <= IDLE_LEVEL;
        flag_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        rcnt      <= '0;
`endif
      end else begin
        state     <= state_d;
        dcnt      <= dcnt_d;
        hcnt      <= hcnt_d;
        long_done <= long_done_d;
        value_q   <= value_d;
        flag_q    <= flag_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        rcnt      <= rcnt_d;
`endif
      end
    end

    // Next-state logic: debounce both edges, count hold time, raise pulses
    always_comb begin
      state_d     = state;
      dcnt_d      = dcnt;
      hcnt_d      = hcnt;
      long_done_d = long_done;
      value_d     = value_q;
      flag_d      = 1'b0;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rcnt_d      = rcnt;
`endif
      case (state)
        ST_UP: begin
          if (key_s != IDLE_LEVEL) begin
            state_d = ST_DN_CHK;
            dcnt_d  = '0;
          end
        end
        ST_DN_CHK: begin
          if (key_s == IDLE_LEVEL) begin
            state_d = ST_UP;
          end else if (dcnt == DCNT_LAST) begin
            state_d     = ST_DOWN;
            hcnt_d      = '0;
            long_done_d = 1'b0;
            value_d     = ~IDLE_LEVEL;
            press_d     = 1'b1;
            flag_d      = 1'b1;
          end else begin
            dcnt_d = dcnt + 1'b1;
          end
        end
        ST_DOWN: begin
          if (key_s == IDLE_LEVEL) begin
            state_d = ST_UP_CHK;
            dcnt_d  = '0;
          end else begin
            // hcnt saturates at LONG_CNT-1; long_done keeps key_long to one pulse per hold
            if (hcnt != HCNT_LAST) begin
              hcnt_d = hcnt + 1'b1;
            end
            if ((hcnt == HCNT_LAST) && !long_done) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
              rcnt_d      = '0;
`endif
            end
`ifdef KEY_DEBOUNCE_REPEAT_EN
            else if (long_done) begin
              if (rcnt == RCNT_LAST) begin
                rcnt_d  = '0;
                press_d = 1'b1;
              end else begin
                rcnt_d = rcnt + 1'b1;
              end
            end
`endif
          end
        end
        ST_UP_CHK: begin
          // hcnt (and repeat phase) stay frozen here so a short glitch does not reset the hold
          if (key_s != IDLE_LEVEL) begin
            state_d = ST_DOWN;
          end else if (dcnt == DCNT_LAST) begin
            state_d     = ST_UP;
            value_d     = IDLE_LEVEL;
            release_d   = 1'b1;
            flag_d      = 1'b1;
            hcnt_d      = '0;
            long_done_d = 1'b0;
          end else begin
            dcnt_d = dcnt + 1'b1;
          end
        end
        default: begin
          state_d = ST_UP;
        end
      endcase
    end

    assign key_value[i]   = value_q;
    assign key_flag[i]    = flag_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi
// Self-checking bench for key_debounce_multi with small counts
// (KEY_NUM=4, DEBOUNCE_CNT=8, LONG_CNT=32, REPEAT_CNT=16, active-low keys).
// A sample-level model predicts every output each cycle; directed scenarios
// add literal expectations at known cycle numbers.
module tb_key_debounce_multi;

  localparam int   KEY_NUM = 4;
  localparam int   DEB     = 8;
  localparam int   LONG    = 32;
  localparam int   REP     = 16;
  localparam logic IDLE    = 1'b1;

  logic               sys_clk   = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic [KEY_NUM-1:0] key       = 4'hF;
  logic [KEY_NUM-1:0] key_value, key_flag, key_press, key_release, key_long;

  int tests_run    = 0;
  int tests_failed = 0;

  key_debounce_multi #(
    .KEY_NUM     (KEY_NUM),
    .DEBOUNCE_CNT(DEB),
    .LONG_CNT    (LONG),
    .REPEAT_CNT  (REP),
    .IDLE_LEVEL  (IDLE)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key        (key),
    .key_value  (key_value),
    .key_flag   (key_flag),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  // 100 MHz-style free-running clock for the bench
  always #5 sys_clk = ~sys_clk;

  // Model state: raw samples delayed two edges, run length of samples that
  // disagree with the accepted level, and cycles spent settled-pressed.
  logic [KEY_NUM-1:0] hist0   = 4'hF;
  logic [KEY_NUM-1:0] hist1   = 4'hF;
  logic [KEY_NUM-1:0] sample  = 4'hF;
  logic [KEY_NUM-1:0] m_value = 4'hF;
  logic [KEY_NUM-1:0] m_flag  = '0;
  logic [KEY_NUM-1:0] m_press = '0;
  logic [KEY_NUM-1:0] m_rel   = '0;
  logic [KEY_NUM-1:0] m_long  = '0;
  int run  [KEY_NUM] = '{default: 0};
  int hold [KEY_NUM] = '{default: 0};

  // A level change is accepted after DEB+1 consecutive disagreeing samples;
  // long fires on the LONG-th settled-pressed cycle, repeats every REP after
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hist0   = 4'hF;
      hist1   = 4'hF;
      m_value = 4'hF;
      m_flag  = '0;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      run     = '{default: 0};
      hold    = '{default: 0};
    end else begin
      sample  = hist1;
      hist1   = hist0;
      hist0   = key;
      m_flag  = '0;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      for (int c = 0; c < KEY_NUM; c++) begin
        if (sample[c] != m_value[c]) begin
          run[c]++;
          if (run[c] == DEB + 1) begin
            run[c]     = 0;
            m_flag[c]  = 1'b1;
            m_value[c] = sample[c];
            if (sample[c] != IDLE) begin
              m_press[c] = 1'b1;
              hold[c]    = 0;
            end else begin
              m_rel[c] = 1'b1;
            end
          end
        end else begin
          if ((m_value[c] != IDLE) && (run[c] == 0)) begin
            hold[c]++;
            if (hold[c] == LONG) begin
              m_long[c] = 1'b1;
            end
`ifdef KEY_DEBOUNCE_REPEAT_EN
            else if ((hold[c] > LONG) && (((hold[c] - LONG) % REP) == 0)) begin
              m_press[c] = 1'b1;
            end
`endif
          end
          run[c] = 0;
        end
      end
    end
  end

  // Every cycle, compare all DUT outputs against the model on the falling edge
  always @(negedge sys_clk) begin
    checkOutput("mdl_value", 32'(key_value), 32'(m_value));
    checkOutput("mdl_flag", 32'(key_flag), 32'(m_flag));
    checkOutput("mdl_press", 32'(key_press), 32'(m_press));
    checkOutput("mdl_release", 32'(key_release), 32'(m_rel));
    checkOutput("mdl_long", 32'(key_long), 32'(m_long));
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive keys just after a falling edge so they are stable at the next rising edge
  task automatic applyStimulus(input logic [KEY_NUM-1:0] k);
    #1;
    key = k;
  endtask

  task automatic runAndCount(input int n, input int ch, output int presses,
                             output int releases, output int flags);
    presses  = 0;
    releases = 0;
    flags    = 0;
    repeat (n) begin
      @(negedge sys_clk);
      presses  += int'(key_press[ch]);
      releases += int'(key_release[ch]);
      flags    += int'(key_flag[ch]);
    end
  endtask

  // Directed scenarios with literal expectations at known cycle numbers
  initial begin
    int p, r, f, pa, ra, fa;
    logic exp_press;

    // Reset state
    repeat (3) @(negedge sys_clk);
    checkOutput("reset_value", 32'(key_value), 32'hF);
    checkOutput("reset_pulses", 32'(key_flag | key_press | key_release | key_long), 32'h0);
    #1 sys_rst_n = 1'b1;
    runAndCount(4, 0, p, r, f);

    // Reset during a pending DN_CHK discards the press
    applyStimulus(4'hE);
    runAndCount(6, 0, p, r, f);
    #1 sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checkOutput("t1_rst_value", 32'(key_value), 32'hF);
    checkOutput("t1_rst_pulses", 32'(key_flag | key_press | key_release | key_long), 32'h0);
    applyStimulus(4'hF);
    #1 sys_rst_n = 1'b1;
    runAndCount(20, 0, p, r, f);
    checkOutput("t1_no_press", 32'(p), 32'd0);

    // Clean press on key[0], held 20 cycles, then released
    applyStimulus(4'hE);
    for (int k = 1; k <= 20; k++) begin
      @(negedge sys_clk);
      checkOutput("t2_press", 32'(key_press[0]), 32'(k == 11));
      checkOutput("t2_flag", 32'(key_flag[0]), 32'(k == 11));
      checkOutput("t2_value", 32'(key_value[0]), 32'(k < 11));
    end
    applyStimulus(4'hF);
    for (int k = 1; k <= 15; k++) begin
      @(negedge sys_clk);
      checkOutput("t2_release", 32'(key_release[0]), 32'(k == 11));
    end

    // Bouncing key[1]: 5 cycles low / 5 high for 100 cycles
    pa = 0; ra = 0; fa = 0;
    for (int b = 0; b < 10; b++) begin
      applyStimulus(4'hD);
      runAndCount(5, 1, p, r, f);
      pa += p; ra += r; fa += f;
      applyStimulus(4'hF);
      runAndCount(5, 1, p, r, f);
      pa += p; ra += r; fa += f;
    end
    runAndCount(15, 1, p, r, f);
    pa += p; ra += r; fa += f;
    checkOutput("t3_no_press", 32'(pa), 32'd0);
    checkOutput("t3_no_release", 32'(ra), 32'd0);
    checkOutput("t3_no_flag", 32'(fa), 32'd0);
    checkOutput("t3_value", 32'(key_value[1]), 32'd1);

    // Long hold on key[2] for 80 cycles
    applyStimulus(4'hB);
    for (int k = 1; k <= 100; k++) begin
      @(negedge sys_clk);
      exp_press = (k == 11);
`ifdef KEY_DEBOUNCE_REPEAT_EN
      exp_press = exp_press || (k == 59) || (k == 75);
`endif
      checkOutput("t4_press", 32'(key_press[2]), 32'(exp_press));
      checkOutput("t4_long", 32'(key_long[2]), 32'(k == 43));
      checkOutput("t4_release", 32'(key_release[2]), 32'(k == 91));
      checkOutput("t4_flag", 32'(key_flag[2]), 32'((k == 11) || (k == 91)));
      if (k == 80) begin
        applyStimulus(4'hF);
      end
    end
    checkOutput("t4_value", 32'(key_value[2]), 32'd1);

    // Simultaneous press and release of all channels
    applyStimulus(4'h0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge sys_clk);
      checkOutput("t5_press", 32'(key_press), (k == 11) ? 32'hF : 32'h0);
    end
    applyStimulus(4'hF);
    for (int k = 1; k <= 12; k++) begin
      @(negedge sys_clk);
      checkOutput("t5_release", 32'(key_release), (k == 11) ? 32'hF : 32'h0);
    end
    runAndCount(5, 0, p, r, f);

    // Release glitch on key[3]: held, raised 3 cycles, held again
    applyStimulus(4'h7);
    runAndCount(20, 3, p, r, f);
    checkOutput("t6_first_press", 32'(p), 32'd1);
    checkOutput("t6_value_down", 32'(key_value[3]), 32'd0);
    applyStimulus(4'hF);
    runAndCount(3, 3, pa, ra, fa);
    applyStimulus(4'h7);
    runAndCount(30, 3, p, r, f);
    checkOutput("t6_no_release", 32'(ra + r), 32'd0);
    checkOutput("t6_no_press", 32'(pa + p), 32'd0);
    checkOutput("t6_value_held", 32'(key_value[3]), 32'd0);
    applyStimulus(4'hF);
    runAndCount(20, 3, p, r, f);
    checkOutput("t6_final_release", 32'(r), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
